// File: rtl/alu_op_buffer_if.sv
// Request/result handshake bundle between issue logic, alu_op_buffer and the result consumer.
interface alu_op_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [2:0]  out_op;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_c, out_op
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_c, out_op
  );
endinterface

// File: rtl/alu_op_buffer.sv
// Execute-stage request FIFO in front of a combinational alu, with a registered result stage.
// Optional ALU_BUF_OPCHECK_EN: drops requests with undefined ops and raises sticky op_err.
module alu_op_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  alu_op_buffer_if.slave bus,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_c,
  output logic [AW:0]   count
`ifdef ALU_BUF_OPCHECK_EN
  ,
  output logic          op_err
`endif
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [31:0]   mem_a_p0  [DEPTH];
  logic [31:0]   mem_b_p0  [DEPTH];
  logic [2:0]    mem_op_p0 [DEPTH];
  logic [AW-1:0] wr_ptr_p0;
  logic [AW-1:0] rd_ptr_p0;
  logic [AW:0]   cnt_p0;

  logic          vld_p1;
  logic [31:0]   c_p1;
  logic [2:0]    op_p1;

  logic          accept;
  logic          push;
  logic          pop;
  logic          empty;

`ifdef ALU_BUF_OPCHECK_EN
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction
`endif

  assign empty        = (cnt_p0 == '0);
  assign bus.in_ready = (cnt_p0 < FULL_CNT) && reset;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_BUF_OPCHECK_EN
  // Illegal ops still complete the handshake so issue logic never stalls on them.
  assign push = accept && op_legal(bus.in_op);
`else
  assign push = accept;
`endif

  assign pop = !empty && (!vld_p1 || bus.out_ready);

  // Stage p0: request FIFO; head feeds the alu directly
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_p0[wr_ptr_p0]  <= bus.in_a;
      mem_b_p0[wr_ptr_p0]  <= bus.in_b;
      mem_op_p0[wr_ptr_p0] <= bus.in_op;
    end
  end

  assign alu_a  = empty ? '0 : mem_a_p0[rd_ptr_p0];
  assign alu_b  = empty ? '0 : mem_b_p0[rd_ptr_p0];
  assign alu_op = empty ? '0 : mem_op_p0[rd_ptr_p0];
  assign count  = cnt_p0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
      cnt_p0 <= cnt_p0 + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Stage p1: registered alu result, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      c_p1   <= '0;
      op_p1  <= '0;
    end else if (pop) begin
      vld_p1 <= 1'b1;
      c_p1   <= alu_c;
      op_p1  <= alu_op;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_c     = c_p1;
  assign bus.out_op    = op_p1;

`ifdef ALU_BUF_OPCHECK_EN
  always_ff @(posedge clk) begin
    if (!reset)                               op_err <= 1'b0;
    else if (accept && !op_legal(bus.in_op))  op_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_op_buffer.sv
// Directed bench for alu_op_buffer with a behavioural alu and an in-order result scoreboard.
module tb_alu_op_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_c, alu_hold;
  logic [2:0]  alu_op;
  logic [2:0]  count;
`ifdef ALU_BUF_OPCHECK_EN
  logic        op_err;
`endif

  int checks  = 0;
  int errors  = 0;
  int drained = 0;

  typedef struct {
    logic [31:0] c;
    logic [2:0]  op;
    bit          dc;
  } exp_t;
  exp_t sb[$];

  alu_op_buffer_if bus ();

  alu_op_buffer #(.DEPTH(4), .AW(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_c  (alu_c),
    .count  (count)
`ifdef ALU_BUF_OPCHECK_EN
    ,
    .op_err (op_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a >> b[4:0];
      3'd5:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural alu: undefined ops leave the previous result on C.
  always_comb begin
    alu_c = (alu_op <= 3'd5) ? ref_alu(alu_a, alu_b, alu_op) : alu_hold;
  end

  always @(posedge clk) if (alu_op <= 3'd5) alu_hold <= alu_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: record accepted requests, compare drained results in order.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed c=%0h op=%0d expected no result", bus.out_c, bus.out_op);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.dc) check("sb_out_c", bus.out_c, e.c);
        check("sb_out_op", {29'b0, bus.out_op}, {29'b0, e.op});
        drained++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
`ifdef ALU_BUF_OPCHECK_EN
      if (bus.in_op <= 3'd5)
        sb.push_back('{c: ref_alu(bus.in_a, bus.in_b, bus.in_op), op: bus.in_op, dc: 1'b0});
`else
      sb.push_back('{c: ref_alu(bus.in_a, bus.in_b, bus.in_op), op: bus.in_op,
                     dc: (bus.in_op > 3'd5)});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 64) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int d0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;

    // Test 1: reset state and single add latency
    step();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_c", bus.out_c, 0);
    check("rst_out_op", 32'(bus.out_op), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
`ifdef ALU_BUF_OPCHECK_EN
    check("rst_op_err", 32'(op_err), 0);
`endif
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    drive(32'd5, 32'd3, 3'd0);
    step();
    bus.in_valid = 1'b0;
    check("t1_count", 32'(count), 1);
    check("t1_no_bypass", 32'(bus.out_valid), 0);
    step();
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_c", bus.out_c, 32'd8);
    check("t1_out_op", 32'(bus.out_op), 0);
    wait_drain("t1_drain");

    // Test 2: back-pressure fills the FIFO, then results emerge in order
    bus.out_ready = 1'b0;
    drive(32'd10, 32'd3, 3'd1);                 step();
    drive(32'hF0, 32'h3C, 3'd2);                step();
    drive(32'd1, 32'd2, 3'd3);                  step();
    drive(32'h8000_0000, 32'd4, 3'd4);          step();
    drive(32'h8000_0000, 32'd4, 3'd5);          step();
    check("t2_full_count", 32'(count), 4);
    check("t2_full_in_ready", 32'(bus.in_ready), 0);
    drive(32'd1, 32'd1, 3'd0);
    step();
    step();
    bus.in_valid = 1'b0;
    check("t2_full_no_push", 32'(count), 4);
    check("t2_hold_valid", 32'(bus.out_valid), 1);
    check("t2_hold_c", bus.out_c, 32'd7);
    check("t2_hold_op", 32'(bus.out_op), 1);
    check("t2_sb_depth", sb.size(), 5);
    bus.out_ready = 1'b1;
    wait_drain("t2_drain");

    // Test 3: continuous streaming with pointer wrap
    d0 = drained;
    for (int i = 0; i < 16; i++) begin
      drive(32'(i * 7 + 1), 32'(i * 1000), 3'd0);
      step();
      check("t3_count_le1", 32'(count <= 3'd1), 1);
    end
    bus.in_valid = 1'b0;
    wait_drain("t3_drain");
    check("t3_result_count", drained - d0, 16);

    // Test 4: reset mid-operation drops queued and held ops
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'(i + 100), 32'd1, 3'd0);
      step();
    end
    bus.in_valid = 1'b0;
    check("t4_full_count", 32'(count), 4);
    reset = 1'b0;
    step();
    sb.delete();
    check("t4_count", 32'(count), 0);
    check("t4_out_valid", 32'(bus.out_valid), 0);
    check("t4_out_c", bus.out_c, 0);
    check("t4_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t4_in_ready_after", 32'(bus.in_ready), 1);
    step();
    check("t4_stays_empty", 32'(bus.out_valid), 0);

    // Test 5: undefined op followed by 1+1
    d0 = drained;
    drive(32'd7, 32'd9, 3'd6);
    step();
`ifdef ALU_BUF_OPCHECK_EN
    check("t5_op6_dropped", 32'(count), 0);
    check("t5_op_err", 32'(op_err), 1);
`else
    check("t5_op6_queued", 32'(count), 1);
`endif
    drive(32'd1, 32'd1, 3'd0);
    step();
    bus.in_valid = 1'b0;
    wait_drain("t5_drain");
`ifdef ALU_BUF_OPCHECK_EN
    check("t5_result_count", drained - d0, 1);
    check("t5_op_err_sticky", 32'(op_err), 1);
`else
    check("t5_result_count", drained - d0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
